rgmii_tx_ms: RTL and testbench

RGMII_TX_MS -- requirements
Module: rgmii_tx_ms

---
 rtl/rgmii_tx_ms.sv | 182 ++++++++++++++++++
 tb/tb_rgmii_tx_ms.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_tx_ms.sv
// RGMII transmit path with 10/100/1000 rate adaptation and ODDR-ready outputs.
// Optional statistics counters are enabled by defining RGMII_TX_STATS_EN.
module rgmii_tx_ms #(
    parameter int IFG_BYTES = 12,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       speed,
    input  logic             tx_valid,
    input  logic [7:0]       tx_data,
    input  logic             tx_last,
    input  logic             tx_err,
    output logic             tx_ready,
    output logic [3:0]       phy_txd_d1,
    output logic [3:0]       phy_txd_d2,
    output logic             phy_txctl_d1,
    output logic             phy_txctl_d2,
    output logic             phy_txc_d1,
    output logic             phy_txc_d2,
    output logic             busy
`ifdef RGMII_TX_STATS_EN
    ,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] underrun_cnt
`endif
);

    localparam int IFG_W = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, DATA, UNDERRUN, IFG} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       speed_reg, speed_next;
    logic [6:0]       cnt_reg, cnt_next;
    logic [IFG_W-1:0] ifg_reg, ifg_next;
    logic [7:0]       byte_reg, byte_next;
    logic             err_reg, err_next;
    logic             last_reg, last_next;
    logic             live_reg;

    logic             is_1g, is_100;
    logic [6:0]       bt_last, half;
    logic             byte_end, second_half, ifg_end;
    logic [6:0]       phase;
    logic [7:0]       out_byte;
    logic [3:0]       nib;

    assign is_1g       = speed_reg[1];
    assign is_100      = (speed_reg == 2'b01);
    assign bt_last     = is_1g ? 7'd0 : (is_100 ? 7'd9 : 7'd99);
    assign half        = is_100 ? 7'd5 : 7'd50;
    assign byte_end    = (cnt_reg == bt_last);
    assign second_half = !is_1g && (cnt_reg >= half);
    assign phase       = second_half ? (cnt_reg - half) : cnt_reg;
    assign ifg_end     = (state_reg == IFG) && byte_end && (ifg_reg == IFG_W'(IFG_BYTES - 1));

    always_comb begin
        state_next = state_reg;
        speed_next = speed_reg;
        cnt_next   = byte_end ? 7'd0 : cnt_reg + 7'd1;
        ifg_next   = ifg_reg;
        byte_next  = byte_reg;
        err_next   = err_reg;
        last_next  = last_reg;
        tx_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                tx_ready = live_reg;
                cnt_next = 7'd0;
                if (tx_valid && live_reg) begin
                    state_next = DATA;
                    speed_next = speed;
                    byte_next  = tx_data;
                    err_next   = tx_err;
                    last_next  = tx_last;
                end
            end
            DATA: begin
                tx_ready = byte_end && !last_reg;
                if (byte_end) begin
                    if (last_reg) begin
                        state_next = IFG;
                        ifg_next   = '0;
                    end else if (tx_valid) begin
                        byte_next = tx_data;
                        err_next  = tx_err;
                        last_next = tx_last;
                    end else begin
                        state_next = UNDERRUN;
                    end
                end
            end
            UNDERRUN: begin
                if (byte_end) begin
                    state_next = IFG;
                    ifg_next   = '0;
                end
            end
            IFG: begin
                if (byte_end) ifg_next = ifg_reg + 1'b1;
                // Ready in the final gap cycle so back-to-back frames keep exactly IFG_BYTES idle bytes.
                if (ifg_end) begin
                    tx_ready   = 1'b1;
                    state_next = IDLE;
                    if (tx_valid) begin
                        state_next = DATA;
                        speed_next = speed;
                        byte_next  = tx_data;
                        err_next   = tx_err;
                        last_next  = tx_last;
                        cnt_next   = 7'd0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            speed_reg <= 2'b10;
            cnt_reg   <= '0;
            ifg_reg   <= '0;
            byte_reg  <= '0;
            err_reg   <= 1'b0;
            last_reg  <= 1'b0;
            live_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            speed_reg <= speed_next;
            cnt_reg   <= cnt_next;
            ifg_reg   <= ifg_next;
            byte_reg  <= byte_next;
            err_reg   <= err_next;
            last_reg  <= last_next;
            live_reg  <= 1'b1;
        end
    end

    assign out_byte = (state_reg == DATA) ? byte_reg : 8'h00;
    assign nib      = second_half ? out_byte[7:4] : out_byte[3:0];

    always_comb begin
        phy_txd_d1   = is_1g ? out_byte[3:0] : nib;
        phy_txd_d2   = is_1g ? out_byte[7:4] : nib;
        phy_txctl_d1 = (state_reg == DATA) || (state_reg == UNDERRUN);
        phy_txctl_d2 = (state_reg == DATA) && !err_reg;
        busy         = (state_reg != IDLE);
        if (state_reg == IDLE) begin
            // Clock parked high between frames; 1G keeps the free-running pattern.
            phy_txc_d1 = live_reg;
            phy_txc_d2 = live_reg && !speed[1];
        end else if (is_1g) begin
            phy_txc_d1 = 1'b1;
            phy_txc_d2 = 1'b0;
        end else if (is_100) begin
            phy_txc_d1 = (phase < 7'd3);
            phy_txc_d2 = (phase < 7'd2);
        end else begin
            // Low half first so each nibble boundary lands on a falling txc edge.
            phy_txc_d1 = (phase >= 7'd25);
            phy_txc_d2 = (phase >= 7'd25);
        end
    end

`ifdef RGMII_TX_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt    <= '0;
            underrun_cnt <= '0;
        end else begin
            if (state_next == IFG && state_reg != IFG && frame_cnt != {CNT_W{1'b1}})
                frame_cnt <= frame_cnt + 1'b1;
            if (state_next == UNDERRUN && state_reg != UNDERRUN && underrun_cnt != {CNT_W{1'b1}})
                underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rgmii_tx_ms.sv
// Bench for rgmii_tx_ms: queue-based output schedule model plus literal frame checks.
module tb_rgmii_tx_ms;
    localparam int IFG_BYTES = 12;
    localparam int CNT_W     = 16;
    localparam logic [1:0] PLAIN = 2'd0, BEND = 2'd1, LEND = 2'd2, IEND = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] speed = 2'b10;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_err = 1'b0;
    logic       tx_ready, phy_txctl_d1, phy_txctl_d2, phy_txc_d1, phy_txc_d2, busy;
    logic [3:0] phy_txd_d1, phy_txd_d2;
`ifdef RGMII_TX_STATS_EN
    logic [CNT_W-1:0] frame_cnt, underrun_cnt;
`endif

    rgmii_tx_ms #(.IFG_BYTES(IFG_BYTES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .speed(speed), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last), .tx_err(tx_err), .tx_ready(tx_ready),
        .phy_txd_d1(phy_txd_d1), .phy_txd_d2(phy_txd_d2),
        .phy_txctl_d1(phy_txctl_d1), .phy_txctl_d2(phy_txctl_d2),
        .phy_txc_d1(phy_txc_d1), .phy_txc_d2(phy_txc_d2), .busy(busy)
`ifdef RGMII_TX_STATS_EN
        , .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt)
`endif
    );

    always #4 clk = ~clk;

    typedef struct packed {
        logic [3:0] d1;
        logic [3:0] d2;
        logic c1, c2, k1, k2, rdy, bsy;
        logic [1:0] kind;
    } ent_t;

    ent_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   m_frames = 0;
    int   m_unders = 0;
    int   cyc = 0;
    bit   hs_seen = 0;
    logic [1:0] f_speed = 2'b10;
    logic m_alive;

    int          n_en[16] = '{default: 0};
    int          ifg_len[16] = '{default: 0};
    logic [10:0] cap_log[16][16];
    int          nfr = 0;
    int          cur = 0;
    bit          cap_in = 0;
    bit          cap_ifg = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) m_alive <= 1'b0;
        else      m_alive <= 1'b1;
    end

    function automatic int bt_of(input logic [1:0] s);
        if (s[1]) return 1;
        return (s == 2'b01) ? 10 : 100;
    endfunction

    function automatic logic [1:0] txc_of(input logic [1:0] s, input int i);
        int p;
        if (s[1]) return 2'b10;
        if (s == 2'b01) begin
            p = i % 5;   // clk p of a 5-clk nibble covers half-cycles 2p and 2p+1
            return {(2 * p) < 5, (2 * p + 1) < 5};
        end
        p = i % 50;
        return {p >= 25, p >= 25};
    endfunction

    task automatic push_byte(input logic [7:0] b, input logic e, input logic l, input logic [1:0] s);
        int n;
        ent_t x;
        n = bt_of(s);
        for (int i = 0; i < n; i++) begin
            x = '0;
            if (s[1]) begin
                x.d1 = b[3:0];
                x.d2 = b[7:4];
            end else begin
                x.d1 = (i < n / 2) ? b[3:0] : b[7:4];
                x.d2 = x.d1;
            end
            x.c1 = 1'b1;
            x.c2 = ~e;
            {x.k1, x.k2} = txc_of(s, i);
            x.rdy = (i == n - 1) && !l;
            x.bsy = 1'b1;
            x.kind = (i == n - 1) ? (l ? LEND : BEND) : PLAIN;
            q.push_back(x);
        end
    endtask

    task automatic push_ifg(input logic [1:0] s);
        int n, b;
        ent_t x;
        b = bt_of(s);
        n = IFG_BYTES * b;
        for (int i = 0; i < n; i++) begin
            x = '0;
            {x.k1, x.k2} = txc_of(s, i % b);
            x.rdy = (i == n - 1);
            x.bsy = 1'b1;
            x.kind = (i == n - 1) ? IEND : PLAIN;
            q.push_back(x);
        end
        m_frames++;
    endtask

    task automatic push_under(input logic [1:0] s);
        int n;
        ent_t x;
        n = bt_of(s);
        for (int i = 0; i < n; i++) begin
            x = '0;
            x.c1 = 1'b1;
            {x.k1, x.k2} = txc_of(s, i);
            x.bsy = 1'b1;
            x.kind = PLAIN;
            q.push_back(x);
        end
        m_unders++;
        push_ifg(s);
    endtask

    // Model + compare: runs mid-cycle, checks the DUT, then schedules future cycles.
    always @(negedge clk) begin
        ent_t e;
        logic [1:0] kd;
        logic [13:0] act, ex;
        bit hs;
        cyc++;
        act = {phy_txd_d1, phy_txd_d2, phy_txctl_d1, phy_txctl_d2, phy_txc_d1, phy_txc_d2, tx_ready, busy};
        if (!rst) begin
            q.delete();
            m_frames = 0;
            m_unders = 0;
            hs_seen = 0;
            ex = '0;
            cap_in = 0;
            cap_ifg = 0;
        end else begin
            if (q.size() == 0) begin
                e = '0;
                e.k1 = m_alive;
                e.k2 = m_alive & ~speed[1];
                e.rdy = m_alive;
                kd = IEND;
            end else begin
                e = q[0];
                kd = e.kind;
                void'(q.pop_front());
            end
            ex = {e.d1, e.d2, e.c1, e.c2, e.k1, e.k2, e.rdy, e.bsy};
            hs = tx_valid && e.rdy;
            case (kd)
                BEND: if (hs) push_byte(tx_data, tx_err, tx_last, f_speed);
                      else push_under(f_speed);
                LEND: push_ifg(f_speed);
                IEND: if (hs) begin
                          f_speed = speed;
                          push_byte(tx_data, tx_err, tx_last, speed);
                      end
                default: ;
            endcase
            hs_seen = hs;
            if (phy_txctl_d1 && !cap_in) begin
                cur = nfr;
                if (nfr < 15) nfr++;
                n_en[cur] = 0;
                cap_in = 1;
                cap_ifg = 0;
            end
            if (cap_in && phy_txctl_d1) begin
                if (n_en[cur] < 16)
                    cap_log[cur][n_en[cur]] = {phy_txc_d1, phy_txc_d2, phy_txctl_d2, phy_txd_d2, phy_txd_d1};
                n_en[cur]++;
            end else if (cap_in) begin
                cap_in = 0;
                cap_ifg = 1;
                ifg_len[cur] = 0;
            end
            if (cap_ifg) begin
                ifg_len[cur]++;
                if (tx_ready) cap_ifg = 0;
            end
        end
        compared++;
        if (act !== ex) begin
            mismatched++;
            $display("FAIL cycle %0d outputs{d1,d2,ctl1,ctl2,txc1,txc2,rdy,busy}: got %b required %b", cyc, act, ex);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l, input logic e);
        int n;
        tx_valid = 1'b1;
        tx_data = b;
        tx_last = l;
        tx_err = e;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!hs_seen && n < 400);
        if (!hs_seen) chk("handshake_timeout", 0, 1);
        #1;
        tx_valid = 1'b0;
        tx_data = 8'hEE;   // junk while not handshaking must be ignored
        tx_last = 1'b1;
        tx_err = 1'b1;
        $display("byte 0x%02h last=%0d err=%0d accepted at cycle %0d", b, l, e, cyc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (q.size() != 0 && n < 3000);
        if (q.size() != 0) chk("idle_timeout", 0, 1);
        #1;
    endtask

    initial begin
        #20;
        chk("reset_outputs_zero", int'({phy_txd_d1, phy_txd_d2, phy_txctl_d1, phy_txctl_d2,
                                        phy_txc_d1, phy_txc_d2, tx_ready, busy}), 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // f0: 1G 4-byte frame
        speed = 2'b10;
        send_byte(8'h55, 0, 0); send_byte(8'hD5, 0, 0);
        send_byte(8'hA1, 0, 0); send_byte(8'h3C, 1, 0);
        wait_idle();
        // f1: 100M single byte
        speed = 2'b01;
        send_byte(8'hA5, 1, 0);
        wait_idle();
        // f2: 1G underrun after 2 bytes
        speed = 2'b10;
        send_byte(8'h55, 0, 0); send_byte(8'h01, 0, 0);
        wait_idle();
        // f3: 1G, error flagged on the last byte
        send_byte(8'h11, 0, 0); send_byte(8'h22, 0, 0); send_byte(8'h33, 1, 1);
        wait_idle();
        // f4: 10M with speed switched mid-frame, f5: next frame at 1G
        speed = 2'b00;
        send_byte(8'h12, 0, 0);
        speed = 2'b11;
        send_byte(8'h34, 1, 0);
        wait_idle();
        send_byte(8'h9A, 0, 0); send_byte(8'hBC, 1, 0);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
`ifdef RGMII_TX_STATS_EN
        chk("underrun_cnt", int'(underrun_cnt), 1);
        chk("frame_cnt", int'(frame_cnt), 6);
        chk("frame_cnt_model", int'(frame_cnt), m_frames);
`endif
        // f6: 100M frame aborted by a 1-clk reset
        speed = 2'b01;
        send_byte(8'h77, 0, 0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_outputs_zero", int'({phy_txd_d1, phy_txd_d2, phy_txctl_d1, phy_txctl_d2,
                                              phy_txc_d1, phy_txc_d2, tx_ready, busy}), 0);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", int'(tx_ready), 1);
        // f7: clean 100M frame after reset
        send_byte(8'hC3, 0, 0); send_byte(8'h5A, 1, 0);
        wait_idle();

        chk("f0_en_cycles", n_en[0], 4);
        chk("f0_byte0", int'(cap_log[0][0][7:0]), 8'h55);
        chk("f0_byte1", int'(cap_log[0][1][7:0]), 8'hD5);
        chk("f0_byte2", int'(cap_log[0][2][7:0]), 8'hA1);
        chk("f0_byte3", int'(cap_log[0][3][7:0]), 8'h3C);
        chk("f0_ifg_to_ready", ifg_len[0], 12);
        chk("f1_en_cycles", n_en[1], 10);
        chk("f1_first_nibble", int'(cap_log[1][0][7:0]), 8'h55);
        chk("f1_second_nibble", int'(cap_log[1][5][7:0]), 8'hAA);
        chk("f1_txc_pattern", int'({cap_log[1][0][10:9], cap_log[1][1][10:9], cap_log[1][2][10:9],
                                    cap_log[1][3][10:9], cap_log[1][4][10:9]}), 10'b1111100000);
        chk("f1_ifg_to_ready", ifg_len[1], 120);
        chk("f2_en_cycles", n_en[2], 3);
        chk("f2_underrun_byte", int'(cap_log[2][2][8:0]), 0);
        chk("f2_ifg_to_ready", ifg_len[2], 12);
        chk("f3_last_err_ctl2", int'(cap_log[3][2][8:0]), 9'h033);
        chk("f4_en_cycles_10m", n_en[4], 200);
        chk("f4_first_cycle", int'(cap_log[4][0]), 11'h122);
        chk("f5_en_cycles_1g", n_en[5], 2);
        chk("f7_en_cycles", n_en[7], 20);
`ifdef RGMII_TX_STATS_EN
        chk("frame_cnt_after_reset", int'(frame_cnt), 1);
        chk("underrun_cnt_after_reset", int'(underrun_cnt), m_unders);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
